snake_game_ctrl: RTL and testbench

Game sequencer for the snake datapath: turns debounced button pulses into the `enb`/`valid`/`direction` step stream consumed by the snake body, paces steps with a score-dependent tick timer, and restarts the body via a reset pulse. It also owns the score counter and the prey position (LFSR-placed), and drives the game state seen by the VGA renderer. Sits between the button front end and the snake body, in the same clock domain.

---
 rtl/snake_pkg.sv | 37 +++
 rtl/snake_prey_lfsr.sv | 62 ++++++
 rtl/snake_game_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game sequencer and its prey placer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package snake_pkg;

    // Direction codes as consumed by the snake body.
    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    // Game state encoding seen by the VGA renderer.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_PLAY = 2'd2,
        ST_OVER = 2'd3
    } game_state_t;

    // Default grid maxima (inclusive cell indices).
    localparam int H_LOGIC_MAX_DEF = 31;
    localparam int V_LOGIC_MAX_DEF = 23;

    // Prey cell shown before the first game.
    localparam int PREY_X_RST = 20;
    localparam int PREY_Y_RST = 11;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bit indices 15,13,12,10).
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/snake_prey_lfsr.sv
// Free-running LFSR plus fold-to-grid; holds the current prey cell.
// Latency: prey register updates on the edge where load_i is sampled high.
// Backpressure: none; load_i is a one-cycle request, always honoured.
// Ports: clk_i/rst_i (async active-high), load_i (capture new cell),
//        preyx_o/preyy_o (registered prey cell).
module snake_prey_lfsr
    import snake_pkg::*;
#(
    parameter int H_W   = 5,
    parameter int V_W   = 5,
    parameter int H_MAX = 31,
    parameter int V_MAX = 23
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           load_i,
    output logic [H_W-1:0] preyx_o,
    output logic [V_W-1:0] preyy_o
);

    logic [15:0]    lfsr_q;
    logic [H_W-1:0] preyx_q;
    logic [V_W-1:0] preyy_q;
    logic [H_W-1:0] col_raw, col_cell;
    logic [V_W-1:0] row_raw, row_cell;

    assign col_raw = lfsr_q[H_W-1:0];
    assign row_raw = lfsr_q[H_W+V_W-1:H_W];

    // Out-of-range rows/columns are pulled back by the unused part of the
    // binary range; this lands on-grid as long as the grid covers at
    // least half of that range.
    localparam int ROW_FOLD = (1 << V_W) - 1 - V_MAX;
    assign row_cell = (row_raw > V_W'(V_MAX)) ? row_raw - V_W'(ROW_FOLD) : row_raw;

    generate
        if (H_MAX >= (1 << H_W) - 1) begin : g_col_full
            assign col_cell = col_raw;
        end else begin : g_col_fold
            localparam int COL_FOLD = (1 << H_W) - 1 - H_MAX;
            assign col_cell = (col_raw > H_W'(H_MAX)) ? col_raw - H_W'(COL_FOLD) : col_raw;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q  <= LFSR_SEED;
            preyx_q <= H_W'(PREY_X_RST);
            preyy_q <= V_W'(PREY_Y_RST);
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
            if (load_i) begin
                preyx_q <= col_cell;
                preyy_q <= row_cell;
            end
        end
    end

    assign preyx_o = preyx_q;
    assign preyy_o = preyy_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Game sequencer: buttons -> snake body step stream, tick pacing, score, prey.
// Latency: buttons/score registered (1 cycle); step strobe 1 cycle after tick reload.
// Backpressure: none; button and score pulses are single-cycle and never stalled.
// Ports: clk/rst (async active-high); btn_* one-cycle pulses; snake_score /
//        snake_lose from the body; snake_rst/enb/valid/direction to the body;
//        preyx/preyy/score/game_state/paused to the renderer.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_WIDTH    = 26,
    parameter int TICK_BASE     = 12_500_000,
    parameter int TICK_STEP     = 250_000,
    parameter int TICK_MIN      = 2_500_000,
    parameter int SCORE_WIDTH   = 8,
    parameter int H_LOGIC_WIDTH = 5,
    parameter int V_LOGIC_WIDTH = 5,
    parameter int H_LOGIC_MAX   = H_LOGIC_MAX_DEF,
    parameter int V_LOGIC_MAX   = V_LOGIC_MAX_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btn_up,
    input  logic                     btn_down,
    input  logic                     btn_left,
    input  logic                     btn_right,
    input  logic                     btn_start,
    input  logic                     btn_pause,
    input  logic                     snake_score,
    input  logic                     snake_lose,
    output logic                     snake_rst,
    output logic                     enb,
    output logic                     valid,
    output logic [1:0]               direction,
    output logic [H_LOGIC_WIDTH-1:0] preyx,
    output logic [V_LOGIC_WIDTH-1:0] preyy,
    output logic [SCORE_WIDTH-1:0]   score,
    output logic [1:0]               game_state,
    output logic                     paused
);

    localparam logic [TICK_WIDTH-1:0]  BASE_T    = TICK_WIDTH'(TICK_BASE);
    localparam logic [TICK_WIDTH-1:0]  STEP_T    = TICK_WIDTH'(TICK_STEP);
    localparam logic [TICK_WIDTH-1:0]  MIN_T     = TICK_WIDTH'(TICK_MIN);
    localparam logic [TICK_WIDTH-1:0]  FLOOR_T   = TICK_WIDTH'(TICK_MIN + TICK_STEP);
    localparam logic [TICK_WIDTH-1:0]  ONE_T     = TICK_WIDTH'(1);
    localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;

    game_state_t             state_q, state_d;
    logic [1:0]              init_cnt_q, init_cnt_d;
    dir_t                    dir_q, dir_d, pend_q, pend_d;
    logic [TICK_WIDTH-1:0]   tick_q, tick_d, period_q, period_d;
    logic [SCORE_WIDTH-1:0]  score_q, score_d;
    logic                    valid_q, valid_d, vd1_q, vd2_q;
    logic                    pause_req_q, pause_req_d, paused_q, paused_d;
    logic                    prey_load;
    logic                    req_any;
    dir_t                    req_dir;

    // Simultaneous presses resolve up > down > left > right.
    always_comb begin
        req_any = btn_up | btn_down | btn_left | btn_right;
        req_dir = DIR_RIGHT;
        if (btn_up)        req_dir = DIR_UP;
        else if (btn_down) req_dir = DIR_DOWN;
        else if (btn_left) req_dir = DIR_LEFT;
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        dir_d       = dir_q;
        pend_d      = pend_q;
        tick_d      = tick_q;
        period_d    = period_q;
        score_d     = score_q;
        valid_d     = 1'b0;
        pause_req_d = pause_req_q;
        paused_d    = paused_q;
        prey_load   = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (btn_start) begin
                    state_d    = ST_INIT;
                    init_cnt_d = 2'd0;
                end
            end
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 2'd1;
                if (init_cnt_q == 2'd0) begin
                    score_d     = '0;
                    period_d    = BASE_T;
                    dir_d       = DIR_RIGHT;
                    pend_d      = DIR_RIGHT;
                    pause_req_d = 1'b0;
                    paused_d    = 1'b0;
                    prey_load   = 1'b1;
                end
                if (init_cnt_q == 2'd3) begin
                    state_d = ST_PLAY;
                    tick_d  = period_q - ONE_T;
                end
            end
            ST_PLAY: begin
                if (btn_pause) pause_req_d = ~pause_req_q;
                // The body is mid-step for three cycles after a strobe;
                // freezing it then would split a move.
                if (!(valid_q | vd1_q | vd2_q)) paused_d = pause_req_q;

                if (snake_lose) begin
                    state_d = ST_OVER;
                end else begin
                    if (snake_score) begin
                        score_d   = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_WIDTH'(1);
                        period_d  = (period_q >= FLOOR_T) ? period_q - STEP_T : MIN_T;
                        prey_load = 1'b1;
                    end
                    if (!paused_q) begin
                        if (req_any && ((req_dir ^ dir_q) != 2'b11)) pend_d = req_dir;
                        if (tick_q == '0) begin
                            tick_d  = period_q - ONE_T;
                            valid_d = 1'b1;
                        end else begin
                            tick_d = tick_q - ONE_T;
                        end
                        // Commit one cycle ahead of the strobe so direction is
                        // already settled in the cycle before valid.
                        if (tick_q == ONE_T || period_q == ONE_T) dir_d = pend_d;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            init_cnt_q  <= 2'd0;
            dir_q       <= DIR_RIGHT;
            pend_q      <= DIR_RIGHT;
            tick_q      <= '0;
            period_q    <= BASE_T;
            score_q     <= '0;
            valid_q     <= 1'b0;
            vd1_q       <= 1'b0;
            vd2_q       <= 1'b0;
            pause_req_q <= 1'b0;
            paused_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            tick_q      <= tick_d;
            period_q    <= period_d;
            score_q     <= score_d;
            valid_q     <= valid_d;
            vd1_q       <= valid_q;
            vd2_q       <= vd1_q;
            pause_req_q <= pause_req_d;
            paused_q    <= paused_d;
        end
    end

    snake_prey_lfsr #(
        .H_W   (H_LOGIC_WIDTH),
        .V_W   (V_LOGIC_WIDTH),
        .H_MAX (H_LOGIC_MAX),
        .V_MAX (V_LOGIC_MAX)
    ) u_prey (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (prey_load),
        .preyx_o (preyx),
        .preyy_o (preyy)
    );

    assign snake_rst  = (state_q == ST_INIT) && (init_cnt_q == 2'd0);
    assign enb        = (state_q == ST_PLAY) && !paused_q;
    assign valid      = valid_q;
    assign direction  = dir_q;
    assign score      = score_q;
    assign game_state = state_q;
    assign paused     = paused_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with a short tick (20/2/8).
// Latency: n/a.
// Backpressure: n/a.
module tb_snake_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
    logic       btn_start = 0, btn_pause = 0;
    logic       snake_score = 0, snake_lose = 0;
    logic       snake_rst, enb, valid, paused;
    logic [1:0] direction, game_state;
    logic [4:0] preyx, preyy;
    logic [7:0] score;

    always #5 clk = ~clk;

    snake_game_ctrl #(
        .TICK_WIDTH(26), .TICK_BASE(20), .TICK_STEP(2), .TICK_MIN(8),
        .SCORE_WIDTH(8), .H_LOGIC_WIDTH(5), .V_LOGIC_WIDTH(5),
        .H_LOGIC_MAX(31), .V_LOGIC_MAX(23)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_start(btn_start), .btn_pause(btn_pause),
        .snake_score(snake_score), .snake_lose(snake_lose),
        .snake_rst(snake_rst), .enb(enb), .valid(valid), .direction(direction),
        .preyx(preyx), .preyy(preyy), .score(score),
        .game_state(game_state), .paused(paused)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference prey generator: Fibonacci LFSR, taps 16,14,13,11.
    logic [15:0] m_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [4:0] fold_y(input logic [15:0] l);
        logic [4:0] y;
        y = l[9:5];
        if (y > 5'd23) y = y - 5'd8;
        return y;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input string name, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            tests++;
            fails++;
            $display("FAIL %s: no valid within %0d cycles", name, budget);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},     game_state, 0);
        check({tag, "_enb"},       enb, 0);
        check({tag, "_valid"},     valid, 0);
        check({tag, "_snake_rst"}, snake_rst, 0);
        check({tag, "_paused"},    paused, 0);
        check({tag, "_dir"},       direction, 2'b01);
        check({tag, "_score"},     score, 0);
        check({tag, "_preyx"},     preyx, 20);
        check({tag, "_preyy"},     preyy, 11);
    endtask

    // Per-tick direction requests: {up,down,left,right} pulse masks applied
    // on consecutive cycles right after a strobe, and the direction that
    // must be committed at the next strobe.
    typedef struct packed {
        logic [3:0] req1;
        logic [3:0] req2;
        logic [1:0] exp_dir;
    } dir_vec_t;

    dir_vec_t tbl [9];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v, p, last, r, a, b, nv, exp_score, exp_per;
        logic [4:0] ex, ey;
        logic [1:0] pdir;
        bit found;

        tbl[0] = '{4'b0010, 4'b0000, 2'b01}; // left vs right: reversal, rejected
        tbl[1] = '{4'b1000, 4'b0100, 2'b11}; // up then down: last one wins
        tbl[2] = '{4'b0001, 4'b0000, 2'b01}; // right from down
        tbl[3] = '{4'b1110, 4'b0000, 2'b00}; // up+down+left: up has priority
        tbl[4] = '{4'b0100, 4'b0000, 2'b00}; // down vs up: rejected
        tbl[5] = '{4'b0011, 4'b0000, 2'b10}; // left+right: left has priority
        tbl[6] = '{4'b0001, 4'b0000, 2'b10}; // right vs left: rejected
        tbl[7] = '{4'b1000, 4'b0001, 2'b00}; // right checked against committed left
        tbl[8] = '{4'b0000, 4'b0000, 2'b00}; // no request: hold

        // Reset
        repeat (3) step();
        check_reset_values("in_reset");
        rst = 1'b0;
        step();
        check("idle_after_reset", game_state, 0);

        // Non-start buttons ignored in IDLE
        btn_up = 1; btn_pause = 1;
        step();
        btn_up = 0; btn_pause = 0;
        step();
        check("idle_ignore_state", game_state, 0);
        check("idle_ignore_dir", direction, 2'b01);
        check("idle_ignore_pause", paused, 0);

        // Start sequence
        btn_start = 1;
        step();
        btn_start = 0;
        check("start_snake_rst", snake_rst, 1);
        check("start_state_init", game_state, 1);
        ex = m_lfsr[4:0];
        ey = fold_y(m_lfsr);
        step();
        check("snake_rst_one_cycle", snake_rst, 0);
        check("init_preyx", preyx, ex);
        check("init_preyy", preyy, ey);
        step(); step();
        check("init_last_cycle", game_state, 1);
        step();
        check("play_entry", game_state, 2);
        check("play_enb", enb, 1);
        p = cyc;

        btn_start = 1;
        step();
        btn_start = 0;
        check("play_start_ignored", game_state, 2);
        check("play_no_snake_rst", snake_rst, 0);

        wait_valid("first_valid", 40, v);
        check("first_valid_latency", v - p, 20);
        check("first_valid_dir", direction, 2'b01);
        last = v;

        // Direction request table
        for (int i = 0; i < 9; i++) begin
            {btn_up, btn_down, btn_left, btn_right} = tbl[i].req1;
            step();
            {btn_up, btn_down, btn_left, btn_right} = tbl[i].req2;
            check($sformatf("valid_one_cycle_%0d", i), valid, 0);
            step();
            {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
            found = 0;
            pdir  = direction;
            for (int k = 0; k < 40; k++) begin
                pdir = direction;
                step();
                if (valid === 1'b1) begin
                    found = 1;
                    break;
                end
            end
            check($sformatf("dir_vec%0d_found", i), found, 1);
            check($sformatf("dir_vec%0d_spacing", i), cyc - last, 20);
            check($sformatf("dir_vec%0d_dir", i), direction, tbl[i].exp_dir);
            check($sformatf("dir_vec%0d_dir_before", i), pdir, tbl[i].exp_dir);
            last = cyc;
        end

        // Seven prey captures: score, period floor, prey placement
        step();
        exp_score = 0;
        exp_per   = 20;
        for (int s = 0; s < 7; s++) begin
            snake_score = 1;
            ex = m_lfsr[4:0];
            ey = fold_y(m_lfsr);
            step();
            snake_score = 0;
            exp_score++;
            exp_per = (exp_per - 2 < 8) ? 8 : exp_per - 2;
            check($sformatf("score_%0d", s), score, exp_score);
            check($sformatf("preyx_%0d", s), preyx, ex);
            check($sformatf("preyy_%0d", s), preyy, ey);
            check($sformatf("preyy_range_%0d", s), (preyy <= 5'd23), 1);
            step();
        end
        wait_valid("period_a", 40, a);
        wait_valid("period_b", 40, b);
        check("period_floor_spacing", b - a, exp_per);

        // Pause requested one cycle after a strobe
        step();
        btn_pause = 1;
        step();
        btn_pause = 0;
        check("pause_blocked_v2", paused, 0);
        step();
        check("pause_blocked_v3", paused, 0);
        step();
        check("pause_applied", paused, 1);
        check("pause_enb", enb, 0);
        nv = 0;
        repeat (100) begin
            step();
            if (valid === 1'b1) nv++;
        end
        check("pause_no_valid", nv, 0);
        check("pause_held", paused, 1);

        r = cyc;
        btn_pause = 1;
        step();
        btn_pause = 0;
        step();
        check("resume_paused", paused, 0);
        check("resume_enb", enb, 1);
        wait_valid("resume_valid", 40, v);
        // Four of the eight counts elapsed before the freeze; resume takes two cycles.
        check("resume_remaining", v - r, exp_per - 4 + 2);

        // Lose together with score
        step(); step(); step();
        snake_lose = 1; snake_score = 1;
        step();
        snake_lose = 0; snake_score = 0;
        check("lose_state_over", game_state, 3);
        check("lose_score_frozen", score, exp_score);
        check("lose_enb", enb, 0);
        check("lose_preyx_frozen", preyx, ex);
        check("lose_preyy_frozen", preyy, ey);
        nv = 0;
        repeat (25) begin
            step();
            if (valid === 1'b1) nv++;
        end
        check("over_no_valid", nv, 0);
        check("over_held", game_state, 3);

        // Restart from OVER
        btn_start = 1;
        step();
        btn_start = 0;
        check("restart_snake_rst", snake_rst, 1);
        step(); step(); step(); step();
        check("restart_play", game_state, 2);
        check("restart_score", score, 0);
        check("restart_dir", direction, 2'b01);
        p = cyc;
        wait_valid("restart_valid", 40, v);
        check("restart_period", v - p, 20);
        check("restart_valid_dir", direction, 2'b01);

        // Score saturation
        snake_score = 1;
        repeat (260) step();
        snake_score = 0;
        check("score_saturate", score, 255);

        // Asynchronous reset in the cycle after a strobe
        wait_valid("pre_reset_valid", 40, v);
        step();
        rst = 1;
        #1;
        check_reset_values("mid_reset");
        step();
        rst = 0;
        step();
        check("post_reset_idle", game_state, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
